// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: the control states and
// the instruction word size in bytes.
package fetch_unit_pkg;

    // FETCH: a memory read is outstanding. HOLD: an instruction is presented to decode.
    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

    localparam int unsigned INSTR_BYTES = 4;

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit_flopr.sv
// Width-parameterised register with asynchronous active-high reset and
// a load enable. Used for the PC, the held instruction and its PC+4.
module flopr #(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load d when enabled; reset takes effect immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : flopr

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one word at the current PC, holds the
// returned instruction for decode until it is consumed, then computes the
// next PC from the jump/branch controls of that held instruction.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pcplus4,
    input  logic        pcsrc,
    input  logic        jump,
    input  logic [31:0] signimm,
    output logic [31:0] fetch_count
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q;
    logic [31:0]  pcplus4_q, pcplus4_d;
    logic [31:0]  fetch_count_q, fetch_count_d;
    logic         capture;   // memory word accepted this cycle
    logic         consume;   // held instruction retired this cycle

    // Handshake qualifiers; the controls and the ack are only meaningful in their own state.
    always_comb begin
        capture = (state_q == FETCH) && imem_ack;
        consume = (state_q == HOLD) && instr_ready;
    end

    // Next state and fetch counter.
    always_comb begin
        state_d       = state_q;
        fetch_count_d = fetch_count_q;
        if (capture) begin
            state_d = HOLD;
        end
        if (consume) begin
            state_d       = FETCH;
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    // Next PC for the held instruction: jump beats taken branch beats fall-through.
    always_comb begin
        pcplus4_d = pc_q + 32'(INSTR_BYTES);
        if (jump) begin
            pc_d = {pcplus4_q[31:28], instr_q[25:0], 2'b00};
        end else if (pcsrc) begin
            pc_d = pcplus4_q + (signimm << 2);
        end else begin
            pc_d = pcplus4_q;
        end
    end

    // State register and consumed-instruction counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= FETCH;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    flopr #(.WIDTH(32), .RESET_VAL(RESET_PC)) u_pc (
        .clk   (clk),
        .reset (reset),
        .en    (consume),
        .d     (pc_d),
        .q     (pc_q)
    );

    flopr #(.WIDTH(32), .RESET_VAL(32'h0)) u_instr (
        .clk   (clk),
        .reset (reset),
        .en    (capture),
        .d     (imem_rdata),
        .q     (instr_q)
    );

    flopr #(.WIDTH(32), .RESET_VAL(32'h0)) u_pcplus4 (
        .clk   (clk),
        .reset (reset),
        .en    (capture),
        .d     (pcplus4_d),
        .q     (pcplus4_q)
    );

    // Outputs are pure functions of state and registers.
    always_comb begin
        imem_req    = (state_q == FETCH);
        imem_addr   = pc_q;
        instr_valid = (state_q == HOLD);
        instr       = instr_q;
        pcplus4     = pcplus4_q;
        fetch_count = fetch_count_q;
    end

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of fetch/consume transactions with
// hand-computed addresses, plus short sequences for reset and PC wrap.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;

    logic        imem_req, instr_valid, imem_ack, instr_ready, pcsrc, jump;
    logic [31:0] imem_addr, imem_rdata, instr, pcplus4, signimm, fetch_count;

    logic        w_imem_req, w_instr_valid, w_imem_ack, w_instr_ready, w_pcsrc, w_jump;
    logic [31:0] w_imem_addr, w_imem_rdata, w_instr, w_pcplus4, w_signimm, w_fetch_count;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .pcplus4(pcplus4), .pcsrc(pcsrc), .jump(jump), .signimm(signimm),
        .fetch_count(fetch_count)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_ack(w_imem_ack), .imem_rdata(w_imem_rdata),
        .instr(w_instr), .instr_valid(w_instr_valid), .instr_ready(w_instr_ready),
        .pcplus4(w_pcplus4), .pcsrc(w_pcsrc), .jump(w_jump), .signimm(w_signimm),
        .fetch_count(w_fetch_count)
    );

    typedef struct {
        int          ack_wait;   // cycles in FETCH before ack
        int          hold;       // cycles in HOLD before ready
        logic [31:0] rdata;
        logic        pcsrc;
        logic        jump;
        logic [31:0] signimm;
        logic [31:0] exp_pc;
        logic [31:0] exp_pcplus4;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{0, 5, 32'h8C08_0004, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004, 32'h0000_0004};
        vecs[1] = '{2, 0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0007, 32'h0000_0004, 32'h0000_0008, 32'h0000_0008};
        vecs[2] = '{0, 1, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0008, 32'h0000_000C, 32'h0000_000C};
        vecs[3] = '{1, 0, 32'h1000_0000, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0000_000C, 32'h0000_0010, 32'h0000_0008};
        vecs[4] = '{0, 0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0008, 32'h0000_000C, 32'h0000_000C};
        vecs[5] = '{0, 2, 32'h0800_0040, 1'b1, 1'b1, 32'h0000_0005, 32'h0000_000C, 32'h0000_0010, 32'h0000_0100};
        vecs[6] = '{3, 0, 32'h0BFF_FFFF, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0100, 32'h0000_0104, 32'h0FFF_FFFC};
        vecs[7] = '{0, 0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 32'h0FFF_FFFC, 32'h1000_0000, 32'h1000_0000};
        vecs[8] = '{0, 1, 32'h0800_0010, 1'b0, 1'b1, 32'h0000_0000, 32'h1000_0000, 32'h1000_0004, 32'h1000_0040};
        vecs[9] = '{1, 0, 32'h1234_5678, 1'b1, 1'b0, 32'h0000_0003, 32'h1000_0040, 32'h1000_0044, 32'h1000_0050};

        reset = 1'b1;
        imem_ack = 0; imem_rdata = 0; instr_ready = 0; pcsrc = 0; jump = 0; signimm = 0;
        w_imem_ack = 0; w_imem_rdata = 0; w_instr_ready = 0; w_pcsrc = 0; w_jump = 0; w_signimm = 0;
        step();
        step();
        reset = 1'b0;
        step();

        // Reset state
        chk("rst_req", 32'(imem_req), 32'd1);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pcplus4", pcplus4, 32'h0);
        chk("rst_count", fetch_count, 32'h0);

        // PC wrap from the top of the address space
        chk("wrap_rst_addr", w_imem_addr, 32'hFFFF_FFFC);
        w_imem_ack = 1; w_imem_rdata = 32'h0000_0000;
        step();
        w_imem_ack = 0;
        chk("wrap_valid", 32'(w_instr_valid), 32'd1);
        chk("wrap_pcplus4", w_pcplus4, 32'h0);
        w_instr_ready = 1;
        step();
        w_instr_ready = 0;
        chk("wrap_addr", w_imem_addr, 32'h0);
        chk("wrap_count", w_fetch_count, 32'd1);
        chk("wrap_req", 32'(w_imem_req), 32'd1);

        // Table of fetch/consume transactions
        for (int i = 0; i < 10; i++) begin
            $display("vec %0d: pc=%h rdata=%h pcsrc=%0b jump=%0b imm=%h -> next=%h",
                     i, vecs[i].exp_pc, vecs[i].rdata, vecs[i].pcsrc, vecs[i].jump,
                     vecs[i].signimm, vecs[i].exp_next);
            chk("fetch_req", 32'(imem_req), 32'd1);
            chk("fetch_addr", imem_addr, vecs[i].exp_pc);
            chk("fetch_valid", 32'(instr_valid), 32'd0);
            for (int w = 0; w < vecs[i].ack_wait; w++) begin
                imem_ack = 0; pcsrc = 1; jump = 1; signimm = 32'h5555_5555; instr_ready = 1;
                step();
                chk("wait_addr", imem_addr, vecs[i].exp_pc);
                chk("wait_valid", 32'(instr_valid), 32'd0);
                chk("wait_count", fetch_count, 32'(i));
            end
            instr_ready = 0; pcsrc = 0; jump = 0; signimm = 0;
            imem_ack = 1; imem_rdata = vecs[i].rdata;
            step();
            imem_ack = 0;
            chk("ack_valid", 32'(instr_valid), 32'd1);
            chk("ack_instr", instr, vecs[i].rdata);
            chk("ack_pcplus4", pcplus4, vecs[i].exp_pcplus4);
            chk("ack_req", 32'(imem_req), 32'd0);
            for (int h = 0; h < vecs[i].hold; h++) begin
                imem_ack = 1; imem_rdata = 32'hDEAD_BEEF; pcsrc = 1; jump = 1; signimm = 32'h1;
                step();
                chk("hold_instr", instr, vecs[i].rdata);
                chk("hold_pcplus4", pcplus4, vecs[i].exp_pcplus4);
                chk("hold_req", 32'(imem_req), 32'd0);
                chk("hold_valid", 32'(instr_valid), 32'd1);
            end
            imem_ack = 0;
            instr_ready = 1; pcsrc = vecs[i].pcsrc; jump = vecs[i].jump; signimm = vecs[i].signimm;
            step();
            instr_ready = 0; pcsrc = 0; jump = 0; signimm = 0;
            chk("next_addr", imem_addr, vecs[i].exp_next);
            chk("next_count", fetch_count, 32'(i + 1));
            chk("next_req", 32'(imem_req), 32'd1);
        end

        // Reset while waiting for an ack at PC 0x20, then a stale ack
        reset = 1'b1;
        #2;
        reset = 1'b0;
        step();
        imem_ack = 1; imem_rdata = 32'h0800_0008;
        step();
        imem_ack = 0; instr_ready = 1; jump = 1;
        step();
        instr_ready = 0; jump = 0;
        chk("seq_addr20", imem_addr, 32'h20);
        step();
        step();
        chk("seq_wait_addr20", imem_addr, 32'h20);
        #3;
        reset = 1'b1;
        #1;
        $display("async reset at %0t: addr=%h count=%h", $time, imem_addr, fetch_count);
        chk("async_rst_addr", imem_addr, 32'h0);
        chk("async_rst_count", fetch_count, 32'h0);
        chk("async_rst_req", 32'(imem_req), 32'd1);
        chk("async_rst_valid", 32'(instr_valid), 32'd0);
        chk("async_rst_instr", instr, 32'h0);
        #2;
        reset = 1'b0;
        step();
        imem_ack = 1; imem_rdata = 32'hCAFE_0001;
        step();
        imem_ack = 0;
        chk("stale_ack_instr", instr, 32'hCAFE_0001);
        chk("stale_ack_pcplus4", pcplus4, 32'h4);
        chk("stale_ack_valid", 32'(instr_valid), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_fetch_unit
